// File: rtl/demux_1to2_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to2_stream
// Description : Packet-locked 1:2 stream demux with a registered output stage
//               and a completed-packet counter on each output.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1to2_stream #(
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              last_in,
  input  logic              sel_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] a_data_out,
  output logic              a_valid_out,
  output logic              a_last_out,
  input  logic              a_ready_in,
  output logic [DATA_W-1:0] b_data_out,
  output logic              b_valid_out,
  output logic              b_last_out,
  input  logic              b_ready_in,
  output logic [7:0]        a_pkt_cnt_out,
  output logic [7:0]        b_pkt_cnt_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ROUTE_A = 2'd1;
  localparam logic [1:0] S_ROUTE_B = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_tgt_b;
  logic              w_ready;
  logic              w_acc;
  logic              w_load_a;
  logic              w_load_b;

  logic [DATA_W-1:0] r_a_data;
  logic              r_a_valid;
  logic              r_a_last;
  logic [DATA_W-1:0] r_b_data;
  logic              r_b_valid;
  logic              r_b_last;
  logic [7:0]        r_a_cnt;
  logic [7:0]        r_b_cnt;

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: the destination is locked from the first beat until last
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc && !last_in) begin
          w_state_nxt = sel_in ? S_ROUTE_B : S_ROUTE_A;
        end
      end
      S_ROUTE_A, S_ROUTE_B: begin
        if (w_acc && last_in) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: target selection and upstream handshake
  always_comb begin
    w_tgt_b = 1'b0;
    case (r_state)
      S_ROUTE_A: w_tgt_b = 1'b0;
      S_ROUTE_B: w_tgt_b = 1'b1;
      default:   w_tgt_b = sel_in;
    endcase
    w_ready  = rst_n_in && (w_tgt_b ? (!r_b_valid || b_ready_in)
                                    : (!r_a_valid || a_ready_in));
    w_acc    = valid_in && w_ready;
    w_load_a = w_acc && !w_tgt_b;
    w_load_b = w_acc &&  w_tgt_b;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_a_data  <= '0;
      r_a_valid <= 1'b0;
      r_a_last  <= 1'b0;
      r_a_cnt   <= 8'd0;
    end else begin
      if (w_load_a) begin
        r_a_data  <= data_in;
        r_a_last  <= last_in;
        r_a_valid <= 1'b1;
      end else if (a_ready_in) begin
        r_a_valid <= 1'b0;
      end
      if (w_load_a && last_in) begin
        r_a_cnt <= r_a_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_b_data  <= '0;
      r_b_valid <= 1'b0;
      r_b_last  <= 1'b0;
      r_b_cnt   <= 8'd0;
    end else begin
      if (w_load_b) begin
        r_b_data  <= data_in;
        r_b_last  <= last_in;
        r_b_valid <= 1'b1;
      end else if (b_ready_in) begin
        r_b_valid <= 1'b0;
      end
      if (w_load_b && last_in) begin
        r_b_cnt <= r_b_cnt + 8'd1;
      end
    end
  end

  assign ready_out     = w_ready;
  assign a_data_out    = r_a_data;
  assign a_valid_out   = r_a_valid;
  assign a_last_out    = r_a_last;
  assign b_data_out    = r_b_data;
  assign b_valid_out   = r_b_valid;
  assign b_last_out    = r_b_last;
  assign a_pkt_cnt_out = r_a_cnt;
  assign b_pkt_cnt_out = r_b_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to2_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1to2_stream
// Description : Directed + randomized bench for demux_1to2_stream against a
//               queue-based packet routing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1to2_stream;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       last_in = 1'b0;
  logic       sel_in = 1'b0;
  logic       ready_out;
  logic [7:0] a_data_out, b_data_out;
  logic       a_valid_out, a_last_out, b_valid_out, b_last_out;
  logic       a_ready_in = 1'b0;
  logic       b_ready_in = 1'b0;
  logic [7:0] a_pkt_cnt_out, b_pkt_cnt_out;

  demux_1to2_stream #(.DATA_W(8)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .last_in      (last_in),
    .sel_in       (sel_in),
    .ready_out    (ready_out),
    .a_data_out   (a_data_out),
    .a_valid_out  (a_valid_out),
    .a_last_out   (a_last_out),
    .a_ready_in   (a_ready_in),
    .b_data_out   (b_data_out),
    .b_valid_out  (b_valid_out),
    .b_last_out   (b_last_out),
    .b_ready_in   (b_ready_in),
    .a_pkt_cnt_out(a_pkt_cnt_out),
    .b_pkt_cnt_out(b_pkt_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each output is a FIFO of beats not yet taken downstream;
  // a packet's destination is fixed by its first beat.
  typedef struct {logic [7:0] d; logic l;} beat_t;
  beat_t qa[$];
  beat_t qb[$];
  bit    m_init   = 0;
  bit    m_in_pkt = 0;
  bit    m_dest   = 0;
  int    m_cnt_a  = 0;
  int    m_cnt_b  = 0;

  always @(negedge clk_in) begin
    bit tgt, exp_ready, acc;
    beat_t nb;
    tgt       = m_in_pkt ? m_dest : sel_in;
    exp_ready = rst_n_in && (tgt ? (qb.size() == 0 || b_ready_in)
                                 : (qa.size() == 0 || a_ready_in));
    if (m_init) begin
      chk("ready_out", 32'(ready_out), 32'(exp_ready));
      chk("a_valid", 32'(a_valid_out), 32'(qa.size() != 0));
      chk("b_valid", 32'(b_valid_out), 32'(qb.size() != 0));
      if (qa.size() != 0) begin
        chk("a_data", 32'(a_data_out), 32'(qa[0].d));
        chk("a_last", 32'(a_last_out), 32'(qa[0].l));
      end
      if (qb.size() != 0) begin
        chk("b_data", 32'(b_data_out), 32'(qb[0].d));
        chk("b_last", 32'(b_last_out), 32'(qb[0].l));
      end
      chk("a_cnt", 32'(a_pkt_cnt_out), 32'(m_cnt_a % 256));
      chk("b_cnt", 32'(b_pkt_cnt_out), 32'(m_cnt_b % 256));
    end
    if (!rst_n_in) begin
      qa.delete();
      qb.delete();
      m_in_pkt = 0;
      m_cnt_a  = 0;
      m_cnt_b  = 0;
      m_init   = 1;
    end else begin
      acc = valid_in && exp_ready;
      if (qa.size() != 0 && a_ready_in) void'(qa.pop_front());
      if (qb.size() != 0 && b_ready_in) void'(qb.pop_front());
      if (acc) begin
        nb.d = data_in;
        nb.l = last_in;
        if (tgt) qb.push_back(nb); else qa.push_back(nb);
        if (last_in) begin
          m_in_pkt = 0;
          if (tgt) m_cnt_b++; else m_cnt_a++;
        end else begin
          m_in_pkt = 1;
          m_dest   = tgt;
        end
      end
    end
  end

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Presents one beat until accepted; returns cycles spent.
  task automatic send(input logic [7:0] d, input logic l, input logic s, output int waits);
    bit ok;
    data_in  = d;
    last_in  = l;
    sel_in   = s;
    valid_in = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk_in);
      ok = ready_out;
      @(posedge clk_in);
      #1;
      waits++;
      if (ok) break;
      if (waits >= 64) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n_in = 1'b0;
    repeat (2) begin
      @(posedge clk_in);
      #1;
    end
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_valids", 32'({a_valid_out, b_valid_out, a_last_out, b_last_out}), 32'd0);
    chk("rst_data", 32'({a_data_out, b_data_out}), 32'd0);
    chk("rst_cnts", 32'({a_pkt_cnt_out, b_pkt_cnt_out}), 32'd0);
    rst_n_in = 1'b1;

    // Single-beat packet to B
    a_ready_in = 1'b1;
    b_ready_in = 1'b1;
    send(8'h5A, 1'b1, 1'b1, w);
    chk("single_b_valid", 32'(b_valid_out), 32'd1);
    chk("single_b_data", 32'(b_data_out), 32'h5A);
    chk("single_a_valid", 32'(a_valid_out), 32'd0);
    chk("single_b_cnt", 32'(b_pkt_cnt_out), 32'd1);
    idle(1);

    // Packet lock: sel toggles after first beat, everything must land on A
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), 1'(i == 4), 1'(~i[0]), w);
      chk("lock_a_data", 32'(a_data_out), 32'(i));
      chk("lock_b_valid", 32'(b_valid_out), 32'd0);
    end
    chk("lock_a_cnt", 32'(a_pkt_cnt_out), 32'd1);
    chk("lock_b_cnt", 32'(b_pkt_cnt_out), 32'd1);
    idle(1);

    // Backpressure on A
    a_ready_in = 1'b0;
    send(8'h21, 1'b0, 1'b0, w);
    data_in  = 8'h22;
    last_in  = 1'b0;
    valid_in = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      chk("bp_ready", 32'(ready_out), 32'd0);
      chk("bp_a_data", 32'(a_data_out), 32'h21);
      @(posedge clk_in);
      #1;
    end
    a_ready_in = 1'b1;
    send(8'h22, 1'b0, 1'b1, w);
    chk("bp_resume_wait", 32'(w), 32'd1);
    chk("bp_resume_data", 32'(a_data_out), 32'h22);
    send(8'h23, 1'b1, 1'b1, w);
    idle(2);

    // Independent drain: B stalls while A streams at full rate
    b_ready_in = 1'b0;
    send(8'h77, 1'b1, 1'b1, w);
    for (int i = 0; i < 4; i++) begin
      send(8'h40 + 8'(i), 1'(i == 3), 1'(i != 0), w);
      chk("drain_full_rate", 32'(w), 32'd1);
      chk("drain_b_hold", 32'(b_data_out), 32'h77);
      chk("drain_b_valid", 32'(b_valid_out), 32'd1);
    end
    b_ready_in = 1'b1;
    idle(1);
    chk("drain_b_cleared", 32'(b_valid_out), 32'd0);

    // Counter wrap on A
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 1'b1, 1'b0, w);
      if (i == 254) chk("wrap_cnt_255", 32'(a_pkt_cnt_out), 32'd255);
    end
    chk("wrap_cnt_0", 32'(a_pkt_cnt_out), 32'd0);
    idle(1);

    // Reset mid-packet to B
    send(8'h31, 1'b0, 1'b1, w);
    send(8'h32, 1'b0, 1'b1, w);
    do_reset();
    chk("midrst_b_valid", 32'(b_valid_out), 32'd0);
    chk("midrst_cnts", 32'({a_pkt_cnt_out, b_pkt_cnt_out}), 32'd0);
    send(8'h99, 1'b1, 1'b0, w);
    chk("midrst_a_data", 32'(a_data_out), 32'h99);
    chk("midrst_a_valid", 32'(a_valid_out), 32'd1);
    chk("midrst_b_idle", 32'(b_valid_out), 32'd0);
    idle(1);

    // Randomized traffic including occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst_n_in   = ($urandom_range(0, 199) != 0);
      valid_in   = ($urandom_range(0, 3) != 0);
      data_in    = 8'($urandom);
      last_in    = ($urandom_range(0, 3) == 0);
      sel_in     = 1'($urandom);
      a_ready_in = ($urandom_range(0, 2) != 0);
      b_ready_in = ($urandom_range(0, 2) != 0);
      @(posedge clk_in);
      #1;
    end
    rst_n_in   = 1'b1;
    a_ready_in = 1'b1;
    b_ready_in = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
